// File: rtl/llr_ctrl_pkg.sv
// rtl/llr_ctrl_pkg.sv - shared widths, FSM state type and parameter check for the LLR frame controller
package llr_ctrl_pkg;

    localparam int LLR_W     = 5;
    localparam int CW_LEN_W  = 16;
    localparam int CW_NUM_W  = 8;
    localparam int PACK_N    = 8;
    localparam int PACK_LSB  = $clog2(PACK_N);
    localparam int FRM_CNT_W = 16;
    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_DEC = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } llr_state_t;

    // A frame is only legal if codewords fill whole packer words and nothing is empty.
    function automatic logic params_ok(input logic [CW_LEN_W-1:0] len,
                                       input logic [CW_NUM_W-1:0] num);
        return (len != '0) && (len[PACK_LSB-1:0] == '0) && (num != '0);
    endfunction

endpackage

// File: rtl/llr_frame_stat.sv
// rtl/llr_frame_stat.sv - completed-frame counter (wrapping) and error counter (saturating)
module llr_frame_stat
    import llr_ctrl_pkg::*;
(
    input  logic                 clk_h,
    input  logic                 rst_n,
    input  logic                 i_frm_inc,
    input  logic                 i_err_inc,
    output logic [FRM_CNT_W-1:0] o_frm_cnt,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    logic [FRM_CNT_W-1:0] r_frm_cnt;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Frame count wraps naturally; error count sticks at all-ones.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            r_frm_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (i_frm_inc) begin
                r_frm_cnt <= r_frm_cnt + {{(FRM_CNT_W-1){1'b0}}, 1'b1};
            end
            if (i_err_inc && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_frm_cnt = r_frm_cnt;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/llr_frame_ctrl.sv
// rtl/llr_frame_ctrl.sv - LLR frame sequencer to the 8-LLR packer; statistics under LLR_FRAME_CTRL_STAT_EN
module llr_frame_ctrl
    import llr_ctrl_pkg::*;
(
    input  logic                 clk_h,
    input  logic                 rst_n,
    input  logic                 istart,
    input  logic [CW_LEN_W-1:0]  icw_len,
    input  logic [CW_NUM_W-1:0]  icw_num,
    input  logic                 iabort,
    input  logic                 ival,
    input  logic [LLR_W-1:0]     ibit,
    input  logic                 idec_rdy,
    output logic                 ordy,
    output logic                 oval,
    output logic                 osop,
    output logic                 oeop,
    output logic                 oeof,
    output logic [LLR_W-1:0]     obit,
    output logic                 obusy,
    output logic                 oerr,
    output logic [FRM_CNT_W-1:0] ofrm_cnt,
    output logic [ERR_CNT_W-1:0] oerr_cnt
);

    llr_state_t          r_state;
    llr_state_t          w_next;

    logic [CW_LEN_W-1:0] r_cw_len;
    logic [CW_NUM_W-1:0] r_cw_num;
    logic [CW_LEN_W-1:0] r_llr_cnt;
    logic [CW_NUM_W-1:0] r_cw_cnt;

    logic                r_oval;
    logic                r_osop;
    logic                r_oeop;
    logic                r_oeof;
    logic [LLR_W-1:0]    r_obit;
    logic                r_oerr;

    logic                w_idle;
    logic                w_run;
    logic                w_params_ok;
    logic                w_start_ok;
    logic                w_accept;
    logic                w_last_llr;
    logic                w_last_cw;
    logic                w_err;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_run       = (r_state == ST_RUN);
    assign w_params_ok = params_ok(icw_len, icw_num);
    assign w_start_ok  = istart && w_idle && w_params_ok && !iabort;
    assign w_accept    = ival && w_run;
    assign w_last_llr  = (r_llr_cnt == (r_cw_len - 16'd1));
    assign w_last_cw   = (r_cw_cnt == (r_cw_num - 8'd1));
    // Dropped LLRs, late starts and bad parameters all share one error pulse.
    assign w_err       = (ival && !w_run) || (istart && (!w_idle || !w_params_ok));

    // State register.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort beats everything else.
    always_comb begin
        w_next = r_state;
        if (iabort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     if (w_start_ok) w_next = ST_WAIT_DEC;
                ST_WAIT_DEC: if (idec_rdy)   w_next = ST_RUN;
                ST_RUN: begin
                    if (w_accept && w_last_llr) begin
                        w_next = w_last_cw ? ST_DONE : ST_WAIT_DEC;
                    end
                end
                ST_DONE:     w_next = ST_IDLE;
                default:     w_next = ST_IDLE;
            endcase
        end
    end

    // Frame parameters and position counters; a new start re-arms everything.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            r_cw_len  <= '0;
            r_cw_num  <= '0;
            r_llr_cnt <= '0;
            r_cw_cnt  <= '0;
        end else if (w_start_ok) begin
            r_cw_len  <= icw_len;
            r_cw_num  <= icw_num;
            r_llr_cnt <= '0;
            r_cw_cnt  <= '0;
        end else if (w_accept && !iabort) begin
            if (w_last_llr) begin
                r_llr_cnt <= '0;
                r_cw_cnt  <= r_cw_cnt + 8'd1;
            end else begin
                r_llr_cnt <= r_llr_cnt + 16'd1;
            end
        end
    end

    // One-cycle output stage; everything is zero unless an LLR was accepted.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            r_oval <= 1'b0;
            r_osop <= 1'b0;
            r_oeop <= 1'b0;
            r_oeof <= 1'b0;
            r_obit <= '0;
            r_oerr <= 1'b0;
        end else begin
            r_oval <= w_accept;
            r_obit <= w_accept ? ibit : '0;
            r_osop <= w_accept && (r_llr_cnt == '0);
            r_oeop <= w_accept && w_last_llr && !iabort;
            r_oeof <= w_accept && w_last_llr && w_last_cw && !iabort;
            r_oerr <= w_err;
        end
    end

    assign ordy  = w_run;
    assign obusy = !w_idle;
    assign oval  = r_oval;
    assign osop  = r_osop;
    assign oeop  = r_oeop;
    assign oeof  = r_oeof;
    assign obit  = r_obit;
    assign oerr  = r_oerr;

`ifdef LLR_FRAME_CTRL_STAT_EN
    llr_frame_stat u_stat (
        .clk_h     (clk_h),
        .rst_n     (rst_n),
        .i_frm_inc ((r_state == ST_DONE) && !iabort),
        .i_err_inc (r_oerr),
        .o_frm_cnt (ofrm_cnt),
        .o_err_cnt (oerr_cnt)
    );
`else
    assign ofrm_cnt = '0;
    assign oerr_cnt = '0;
`endif

endmodule

// File: tb/tb_llr_frame_ctrl.sv
// tb/tb_llr_frame_ctrl.sv - directed and randomized self-checking bench for llr_frame_ctrl
module tb_llr_frame_ctrl;

`ifdef LLR_FRAME_CTRL_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk_h    = 1'b0;
    logic        rst_n    = 1'b0;
    logic        istart   = 1'b0;
    logic [15:0] icw_len  = '0;
    logic [7:0]  icw_num  = '0;
    logic        iabort   = 1'b0;
    logic        ival     = 1'b0;
    logic [4:0]  ibit     = '0;
    logic        idec_rdy = 1'b0;
    logic        ordy, oval, osop, oeop, oeof, obusy, oerr;
    logic [4:0]  obit;
    logic [15:0] ofrm_cnt;
    logic [7:0]  oerr_cnt;

    always #5 clk_h = ~clk_h;

    llr_frame_ctrl dut (
        .clk_h    (clk_h),
        .rst_n    (rst_n),
        .istart   (istart),
        .icw_len  (icw_len),
        .icw_num  (icw_num),
        .iabort   (iabort),
        .ival     (ival),
        .ibit     (ibit),
        .idec_rdy (idec_rdy),
        .ordy     (ordy),
        .oval     (oval),
        .osop     (osop),
        .oeop     (oeop),
        .oeof     (oeof),
        .obit     (obit),
        .obusy    (obusy),
        .oerr     (oerr),
        .ofrm_cnt (ofrm_cnt),
        .oerr_cnt (oerr_cnt)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference: frame position k counts LLRs across the whole frame.
    bit         m_wait, m_run, m_done;
    int         m_k, m_len, m_num, m_frm, m_ecnt;
    bit         e_val, e_sop, e_eop, e_eof, e_err;
    logic [4:0] e_bit;

    // Observed-event tallies for window checks.
    int c_val, c_sop, c_eop, c_eof, c_err, c_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ok_params(input int len, input int num);
        return (len != 0) && (len % 8 == 0) && (num != 0);
    endfunction

    task automatic model_clear();
        m_wait = 0; m_run = 0; m_done = 0;
        m_k = 0; m_len = 0; m_num = 0; m_frm = 0; m_ecnt = 0;
        e_val = 0; e_sop = 0; e_eop = 0; e_eof = 0; e_err = 0; e_bit = '0;
    endtask

    task automatic clr_tally();
        c_val = 0; c_sop = 0; c_eop = 0; c_eof = 0; c_err = 0; c_busy = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ordy"}, ordy, 0);
        chk({tag, "_obusy"}, obusy, 0);
        chk({tag, "_oval"}, oval, 0);
        chk({tag, "_marks"}, {osop, oeop, oeof}, 0);
        chk({tag, "_obit"}, obit, 0);
        chk({tag, "_oerr"}, oerr, 0);
        chk({tag, "_ofrm_cnt"}, ofrm_cnt, 0);
        chk({tag, "_oerr_cnt"}, oerr_cnt, 0);
    endtask

    // One clock: drive inputs, compare DUT against the model, advance the model.
    task automatic cyc(input bit st, input int len, input int num, input bit ab,
                       input bit v, input bit dec);
        logic [4:0] b;
        bit busy, err, acc;
        int pos;
        b = 5'($urandom);
        istart = st; icw_len = 16'(len); icw_num = 8'(num);
        iabort = ab; ival = v; ibit = b; idec_rdy = dec;
        busy = m_wait || m_run || m_done;

        chk("ordy", ordy, m_run);
        chk("obusy", obusy, busy);
        chk("oval", oval, e_val);
        chk("osop", osop, e_sop);
        chk("oeop", oeop, e_eop);
        chk("oeof", oeof, e_eof);
        chk("obit", obit, e_bit);
        chk("oerr", oerr, e_err);
        chk("ofrm_cnt", ofrm_cnt, STAT ? (m_frm & 32'hFFFF) : 0);
        chk("oerr_cnt", oerr_cnt, STAT ? m_ecnt : 0);
        c_val += oval; c_sop += osop; c_eop += oeop; c_eof += oeof;
        c_err += oerr; c_busy += obusy;

        if (e_err && m_ecnt < 255) m_ecnt++;
        err = (v && !m_run) || (st && (busy || !ok_params(len, num)));
        acc = v && m_run;
        pos = acc ? (m_k % m_len) : 0;
        e_err = err;
        e_val = acc;
        e_bit = acc ? b : 5'd0;
        e_sop = acc && (pos == 0);
        e_eop = acc && !ab && (pos == m_len - 1);
        e_eof = acc && !ab && (m_k == m_len * m_num - 1);

        if (ab) begin
            m_wait = 0; m_run = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0; m_frm++;
        end else if (m_wait) begin
            if (dec) begin m_wait = 0; m_run = 1; end
        end else if (m_run) begin
            if (acc) begin
                m_k++;
                if (m_k % m_len == 0) begin
                    m_run = 0;
                    if (m_k == m_len * m_num) m_done = 1;
                    else m_wait = 1;
                end
            end
        end else if (st && ok_params(len, num)) begin
            m_wait = 1; m_k = 0; m_len = len; m_num = num;
        end

        @(posedge clk_h);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int len, num;
        model_clear();
        clr_tally();

        // Reset state.
        #2;
        chk_all_zero("reset");
        @(posedge clk_h);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Two 16-LLR codewords, decoder always ready, ival continuous.
        clr_tally();
        cyc(1, 16, 2, 0, 1, 1);
        for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 1, 1);
        idle(3);
        chk("t035_oval_count", c_val, 32);
        chk("t035_osop_count", c_sop, 2);
        chk("t035_oeop_count", c_eop, 2);
        chk("t035_oeof_count", c_eof, 1);
        chk("t035_ofrm_cnt", ofrm_cnt, STAT ? 1 : 0);

        // Decoder stalls for 10 cycles after codeword 0 while upstream keeps pushing.
        cyc(1, 16, 2, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        clr_tally();
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t036_oerr_pulses", c_err, 10);
        chk("t036_no_oval", c_val, 0);
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1, 0);
        idle(4);

        // Illegal parameters are rejected without leaving IDLE.
        clr_tally();
        cyc(1, 12, 1, 0, 0, 0);
        cyc(1, 16, 0, 0, 0, 0);
        cyc(1, 0, 3, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t037_oerr_pulses", c_err, 3);
        chk("t037_obusy", c_busy, 0);

        // Abort at LLR 5 of codeword 1.
        clr_tally();
        cyc(1, 8, 3, 0, 0, 0);
        for (int i = 0; i < 60; i++) begin
            bit ab;
            ab = m_run && (m_k == 13);
            cyc(0, 0, 0, ab, 1, 1);
            if (ab) break;
        end
        chk("t038_idle_after_abort", obusy, 0);
        idle(10);
        chk("t038_oval_count", c_val, 14);
        chk("t038_oeop_count", c_eop, 1);
        chk("t038_oeof_count", c_eof, 0);

        // Asynchronous reset in the middle of a frame, then a clean frame.
        cyc(1, 8, 2, 0, 0, 0);
        for (int i = 0; i < 20 && !(m_run && m_k == 3); i++) cyc(0, 0, 0, 0, 1, 1);
        ival = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        istart = 0; iabort = 0; ival = 0; idec_rdy = 0;
        model_clear();
        @(posedge clk_h);
        #1;
        rst_n = 1'b1;
        clr_tally();
        cyc(1, 8, 2, 0, 0, 1);
        for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0, 1, 1);
        idle(3);
        chk("t039_oval_count", c_val, 16);
        chk("t039_oeof_count", c_eof, 1);
        chk("t039_ofrm_cnt", ofrm_cnt, STAT ? 1 : 0);

        // Randomized frames with stalls, stray starts and rare aborts.
        for (int f = 0; f < 8; f++) begin
            len = 8 * $urandom_range(1, 6);
            num = $urandom_range(1, 4);
            cyc(1, len, num, 0, ($urandom % 4) == 0, $urandom % 2);
            for (int i = 0; i < 800 && (m_wait || m_run || m_done); i++) begin
                cyc(($urandom % 20) == 0, $urandom_range(0, 40), $urandom_range(0, 3),
                    ($urandom % 300) == 0, ($urandom % 10) < 7, $urandom % 2);
            end
            idle(3);
        end

        // Flood with dropped LLRs so the error count reaches its ceiling.
        for (int i = 0; i < 270; i++) cyc(0, 0, 0, 0, 1, 0);
        idle(3);
        chk("sat_oerr_cnt", oerr_cnt, STAT ? 255 : 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/llr_frame_ctrl.md
LLR_FRAME_CTRL -- requirements
Module: llr_frame_ctrl

Interface
REQ-001 SHALL have port: clk_h  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: istart  in  1  one-cycle pulse; begins a frame.
REQ-004 SHALL have port: icw_len  in  16  codeword length in LLRs; sampled on accepted istart.
REQ-005 SHALL have port: icw_num  in  8  codewords per frame; sampled on accepted istart.
REQ-006 SHALL have port: iabort  in  1  aborts the current frame.
REQ-007 SHALL have port: ival  in  1  upstream demapper LLR valid.
REQ-008 SHALL have port: ibit  in  5  upstream LLR.
REQ-009 SHALL have port: idec_rdy  in  1  decoder can accept one full codeword.
REQ-010 SHALL have port: ordy  out  1  upstream may present LLRs; combinational, equals (state==RUN).
REQ-011 SHALL have ports: oval, osop, oeop, oeof  out  1 each; to the 8-LLR packer.
REQ-012 SHALL have port: obit  out  5  LLR to the packer.
REQ-013 SHALL have ports: obusy  out  1  (state!=IDLE); oerr  out  1  one-cycle error pulse.
REQ-014 SHALL have ports: ofrm_cnt  out  16  completed frames; oerr_cnt  out  8  error count.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_DEC, RUN, DONE.
REQ-016 IDLE + istart with icw_len!=0, icw_len[2:0]==0, icw_num!=0 SHALL latch both values, clear the LLR and codeword counters, and go to WAIT_DEC.
REQ-017 IDLE + istart with invalid parameters SHALL pulse oerr and remain in IDLE.
REQ-018 WAIT_DEC SHALL go to RUN on the first cycle in which idec_rdy=1.
REQ-019 In RUN, each cycle with ival&ordy SHALL accept one LLR; oval=1, obit=ibit on the next cycle (latency 1).
REQ-020 osop SHALL equal 1 with the first LLR of each codeword; oeop SHALL equal 1 with LLR index icw_len-1; oeof SHALL equal 1 only with the last LLR of codeword icw_num-1.
REQ-021 Markers SHALL never assert without oval; all of oval, osop, oeop, oeof and obit SHALL be 0 on cycles with no accepted LLR.
REQ-022 Acceptance of the last LLR of a non-final codeword SHALL move the FSM to WAIT_DEC, so ordy=0 on the following cycle.
REQ-023 Acceptance of the last LLR of the final codeword SHALL move the FSM to DONE; DONE SHALL last one cycle, increment ofrm_cnt (wrap at 2^16), then go to IDLE.
REQ-024 ival=1 while ordy=0 SHALL drop the LLR and pulse oerr.
REQ-025 istart outside IDLE SHALL be ignored and SHALL pulse oerr.
REQ-026 iabort SHALL force IDLE on the next edge, dominating all other events, with no markers emitted afterwards; an LLR accepted in the same cycle SHALL still be output, with oeop and oeof forced to 0.
REQ-027 oerr_cnt SHALL increment on each oerr pulse and saturate at 255.
REQ-028 Because icw_len is a multiple of 8, every osop SHALL land on packer slot 0 and every oeop on packer slot 7.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state IDLE, ordy=0, and all outputs, counters and latched parameters to 0.
REQ-030 Reset asserted mid-frame SHALL discard the frame; there SHALL be no partial oeop/oeof after release.

Configuration
REQ-031 With macro LLR_FRAME_CTRL_STAT_EN defined, ofrm_cnt and oerr_cnt SHALL operate as specified.
REQ-032 Without LLR_FRAME_CTRL_STAT_EN, both counters SHALL be absent from logic and the ports SHALL be tied to 0; oerr SHALL be unaffected.

Structure
REQ-033 Package llr_ctrl_pkg SHALL hold: the FSM state enum; LLR_W=5; CW_LEN_W=16; CW_NUM_W=8; PACK_N=8.
REQ-034 Statistics counters SHALL be placed in a single sub-module, llr_frame_stat; all other logic SHALL be inline.

Verification
REQ-035 Test: istart, icw_len=16, icw_num=2, idec_rdy=1, ival continuous -> 32 oval; osop at LLR 0 and 16; oeop at 15 and 31; oeof at 31 only; ofrm_cnt=1.
REQ-036 Test: idec_rdy=0 for 10 cycles after codeword 0 -> ordy=0 for those cycles; ival during them gives oerr pulses, oerr_cnt=10, and no oval.
REQ-037 Test: istart with icw_len=12 or icw_num=0 -> oerr pulse, obusy stays 0.
REQ-038 Test: iabort at LLR 5 of codeword 1 (icw_len=8, icw_num=3) -> IDLE next cycle, no further oeop/oeof, ofrm_cnt unchanged.
REQ-039 Test: rst_n low at LLR 3 of a frame -> all outputs 0 immediately; a new istart afterwards completes normally.
REQ-040 Test: build without LLR_FRAME_CTRL_STAT_EN and rerun REQ-035 -> identical stream, ofrm_cnt=0.
